// File: rtl/pc_redirect_if.sv
// pc_redirect_if
//   Groups the fetch-PC control signals exchanged between the EX-stage
//   decision logic / pipeline control (master) and pc_redirect_unit (slave).
//
//   master -> slave : le, decision, branch_target, jal_target, jalr_target
//   slave -> master : pc_out, npc_out, if_id_flush, redirect_pending,
//                     misaligned, bad_code, redirect_count[CNT_W-1:0]
interface pc_redirect_if #(
  parameter int CNT_W = 16
);
  logic             le;
  logic [2:0]       decision;
  logic [31:0]      branch_target;
  logic [31:0]      jal_target;
  logic [31:0]      jalr_target;
  logic [31:0]      pc_out;
  logic [31:0]      npc_out;
  logic             if_id_flush;
  logic             redirect_pending;
  logic             misaligned;
  logic             bad_code;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output le, decision, branch_target, jal_target, jalr_target,
    input  pc_out, npc_out, if_id_flush, redirect_pending,
           misaligned, bad_code, redirect_count
  );

  modport slave (
    input  le, decision, branch_target, jal_target, jalr_target,
    output pc_out, npc_out, if_id_flush, redirect_pending,
           misaligned, bad_code, redirect_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Owns the fetch-stage program counter. Each cycle selects sequential
//   PC+4 or a branch / JAL / JALR target from the EX-stage decision code,
//   holds a redirect that arrives during a stall until le returns, and
//   emits a registered IF/ID flush pulse aligned with the redirected PC.
//   Keeps sticky misaligned / bad_code diagnostics and a saturating
//   redirect counter.
//
//   Ports:
//     clk    - sole clock, rising edge
//     reset  - synchronous, active-high; overrides all other inputs
//     bus    - pc_redirect_if.slave (le, decision, targets in;
//              pc_out, npc_out, if_id_flush, redirect_pending,
//              misaligned, bad_code, redirect_count out)
//   All outputs come straight from registers.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  pc_redirect_if.slave       bus
);

  typedef enum logic {RUN, HELD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic [31:0]      hold_q, hold_d;
  logic             flush_q, flush_d;
  logic             pend_q, pend_d;
  logic             mis_q, mis_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      raw_tgt;
  logic [31:0]      tgt;
  logic             is_redir;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  // Decode: pick the raw target for the presented code.
  always_comb begin
    raw_tgt  = 32'h0;
    is_redir = 1'b0;
    case (bus.decision)
      3'b001: begin raw_tgt = bus.branch_target; is_redir = 1'b1; end
      3'b010: begin raw_tgt = bus.jal_target;    is_redir = 1'b1; end
      3'b011: begin raw_tgt = bus.jalr_target;   is_redir = 1'b1; end
      default: begin raw_tgt = 32'h0; is_redir = 1'b0; end
    endcase
    tgt = align_target(raw_tgt);
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    hold_d  = hold_q;
    flush_d = 1'b0;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    // Diagnostics watch the decision input every cycle, stalled or not.
    mis_d   = mis_q | (is_redir & (|raw_tgt[1:0]));
    bad_d   = bad_q | bus.decision[2];

    case (state_q)
      RUN: begin
        if (bus.le) begin
          if (is_redir) begin
            pc_d    = tgt;
            npc_d   = tgt + 32'd4;
            flush_d = 1'b1;
            cnt_d   = sat_inc(cnt_q);
          end else begin
            pc_d  = npc_q;
            npc_d = npc_q + 32'd4;
          end
        end else if (is_redir) begin
          hold_d  = tgt;
          pend_d  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        // The stalled EX instruction keeps re-presenting its code, so the
        // decision input is ignored for PC purposes until the hold drains.
        if (bus.le) begin
          pc_d    = hold_q;
          npc_d   = hold_q + 32'd4;
          flush_d = 1'b1;
          cnt_d   = sat_inc(cnt_q);
          pend_d  = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      hold_q  <= 32'h0;
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      hold_q  <= hold_d;
      flush_q <= flush_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.npc_out          = npc_q;
  assign bus.if_id_flush      = flush_q;
  assign bus.redirect_pending = pend_q;
  assign bus.misaligned       = mis_q;
  assign bus.bad_code         = bad_q;
  assign bus.redirect_count   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit
//   Directed, table-driven bench for pc_redirect_unit. A main instance
//   (CNT_W=16) and a narrow-counter instance (CNT_W=2) share one stimulus.
module tb_pc_redirect_unit;

  logic clk;
  logic reset;

  pc_redirect_if #(.CNT_W(16)) bus ();
  pc_redirect_if #(.CNT_W(2))  bus2 ();

  pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  assign bus2.le            = bus.le;
  assign bus2.decision      = bus.decision;
  assign bus2.branch_target = bus.branch_target;
  assign bus2.jal_target    = bus.jal_target;
  assign bus2.jalr_target   = bus.jalr_target;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        le;
    logic [2:0]  dec;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_fl;
    logic        e_pd;
    logic        e_mis;
    logic        e_bad;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic le, input logic [2:0] dec,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input logic [31:0] jrt, input logic [31:0] e_pc,
                              input logic [31:0] e_npc, input logic e_fl,
                              input logic e_pd, input logic e_mis,
                              input logic e_bad, input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.le = le; v.dec = dec; v.bt = bt; v.jt = jt; v.jrt = jrt;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_fl = e_fl; v.e_pd = e_pd;
    v.e_mis = e_mis; v.e_bad = e_bad; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic step(input logic rst, input logic le, input logic [2:0] dec,
                      input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
    reset             = rst;
    bus.le            = le;
    bus.decision      = dec;
    bus.branch_target = bt;
    bus.jal_target    = jt;
    bus.jalr_target   = jrt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst le dec  bt        jt            jrt       pc            npc           fl pd mis bad cnt
    vecs[0]  = mk(1, 0, 3'd0, 32'h0,  32'h0,        32'h0,   32'h0,        32'h4,        0, 0, 0, 0, 16'd0);
    vecs[1]  = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h4,        32'h8,        0, 0, 0, 0, 16'd0);
    vecs[2]  = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h8,        32'hC,        0, 0, 0, 0, 16'd0);
    vecs[3]  = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'hC,        32'h10,       0, 0, 0, 0, 16'd0);
    vecs[4]  = mk(0, 1, 3'd2, 32'h0,  32'h100,      32'h0,   32'h100,      32'h104,      1, 0, 0, 0, 16'd1);
    vecs[5]  = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h104,      32'h108,      0, 0, 0, 0, 16'd1);
    vecs[6]  = mk(0, 0, 3'd1, 32'h40, 32'h0,        32'h0,   32'h104,      32'h108,      0, 1, 0, 0, 16'd1);
    vecs[7]  = mk(0, 0, 3'd1, 32'h40, 32'h0,        32'h0,   32'h104,      32'h108,      0, 1, 0, 0, 16'd1);
    vecs[8]  = mk(0, 0, 3'd1, 32'h44, 32'h0,        32'h0,   32'h104,      32'h108,      0, 1, 0, 0, 16'd1);
    vecs[9]  = mk(0, 1, 3'd3, 32'h0,  32'h0,        32'h80,  32'h40,       32'h44,       1, 0, 0, 0, 16'd2);
    vecs[10] = mk(0, 1, 3'd3, 32'h0,  32'h0,        32'h80,  32'h80,       32'h84,       1, 0, 0, 0, 16'd3);
    vecs[11] = mk(0, 1, 3'd3, 32'h0,  32'h0,        32'h203, 32'h200,      32'h204,      1, 0, 1, 0, 16'd4);
    vecs[12] = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h204,      32'h208,      0, 0, 1, 0, 16'd4);
    vecs[13] = mk(0, 1, 3'd5, 32'h0,  32'h0,        32'h0,   32'h208,      32'h20C,      0, 0, 1, 1, 16'd4);
    vecs[14] = mk(0, 0, 3'd6, 32'h0,  32'h0,        32'h0,   32'h208,      32'h20C,      0, 0, 1, 1, 16'd4);
    vecs[15] = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h20C,      32'h210,      0, 0, 1, 1, 16'd4);
    vecs[16] = mk(0, 1, 3'd2, 32'h0,  32'hFFFFFFF8, 32'h0,   32'hFFFFFFF8, 32'hFFFFFFFC, 1, 0, 1, 1, 16'd5);
    vecs[17] = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'hFFFFFFFC, 32'h0,        0, 0, 1, 1, 16'd5);
    vecs[18] = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h0,        32'h4,        0, 0, 1, 1, 16'd5);
    vecs[19] = mk(0, 0, 3'd1, 32'h300, 32'h0,       32'h0,   32'h0,        32'h4,        0, 1, 1, 1, 16'd5);
    vecs[20] = mk(1, 1, 3'd2, 32'h0,  32'h500,      32'h0,   32'h0,        32'h4,        0, 0, 0, 0, 16'd0);
    vecs[21] = mk(0, 1, 3'd0, 32'h0,  32'h0,        32'h0,   32'h4,        32'h8,        0, 0, 0, 0, 16'd0);

    reset = 1'b1;
    bus.le = 1'b0;
    bus.decision = 3'd0;
    bus.branch_target = 32'h0;
    bus.jal_target = 32'h0;
    bus.jalr_target = 32'h0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].le, vecs[i].dec, vecs[i].bt, vecs[i].jt, vecs[i].jrt);
      chk($sformatf("v%0d pc_out", i),           bus.pc_out,                  vecs[i].e_pc);
      chk($sformatf("v%0d npc_out", i),          bus.npc_out,                 vecs[i].e_npc);
      chk($sformatf("v%0d if_id_flush", i),      32'(bus.if_id_flush),        32'(vecs[i].e_fl));
      chk($sformatf("v%0d redirect_pending", i), 32'(bus.redirect_pending),   32'(vecs[i].e_pd));
      chk($sformatf("v%0d misaligned", i),       32'(bus.misaligned),         32'(vecs[i].e_mis));
      chk($sformatf("v%0d bad_code", i),         32'(bus.bad_code),           32'(vecs[i].e_bad));
      chk($sformatf("v%0d redirect_count", i),   32'(bus.redirect_count),     32'(vecs[i].e_cnt));
    end

    // Counter saturation: five back-to-back redirects, narrow counter stops at 3.
    // pc is 4 and count is 0 in both instances here.
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 3'd2, 32'h0, 32'(k * 32'h10), 32'h0);
      chk($sformatf("sat%0d cnt_w2", k),  32'(bus2.redirect_count), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat%0d cnt_w16", k), 32'(bus.redirect_count),  32'(k));
      chk($sformatf("sat%0d pc", k),      bus.pc_out,               32'(k * 32'h10));
      chk($sformatf("sat%0d flush", k),   32'(bus.if_id_flush),     32'd1);
    end

    // Misaligned target captured during a stall: flag sets while HELD,
    // the aligned target applies on release with no extra bubble.
    step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    chk("held_rst cnt_w2", 32'(bus2.redirect_count), 32'd0);
    step(1'b0, 1'b0, 3'd1, 32'h42, 32'h0, 32'h0);
    chk("held_mis pending",    32'(bus.redirect_pending), 32'd1);
    chk("held_mis misaligned", 32'(bus.misaligned),       32'd1);
    chk("held_mis pc_frozen",  bus.pc_out,                32'h0);
    step(1'b0, 1'b0, 3'd7, 32'h42, 32'h0, 32'h0);
    chk("held_bad bad_code",   32'(bus.bad_code),         32'd1);
    chk("held_bad pending",    32'(bus.redirect_pending), 32'd1);
    step(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0);
    chk("release pc",      bus.pc_out,                32'h40);
    chk("release npc",     bus.npc_out,               32'h44);
    chk("release flush",   32'(bus.if_id_flush),      32'd1);
    chk("release pending", 32'(bus.redirect_pending), 32'd0);
    step(1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0);
    chk("after pc",    bus.pc_out,           32'h44);
    chk("after flush", 32'(bus.if_id_flush), 32'd0);
    chk("after mis",   32'(bus.misaligned),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
